rom_burst_reader: RTL and testbench

- Sequencer that sits directly upstream of the combinational lookup ROM. It drives the ROM's read_adr and consumes its data_out.
- On a start command it walks a burst of consecutive ROM addresses, wrapping modulo depth.
- It presents each word on a valid/ready output stream with a last flag, so ROM contents can feed downstream logic at one word per cycle.

---
 rtl/rom_burst_reader_pkg.sv | 16 +
 rtl/rom_adr_counter.sv | 30 +++
 rtl/rom_burst_reader.sv | 141 ++++++++++++++
 tb/tb_rom_burst_reader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_reader_pkg.sv
// Shared types and default sizing for the ROM burst reader.
package rom_burst_reader_pkg;

  localparam int K_DEF = 8;  // data width
  localparam int L_DEF = 4;  // ROM depth in words
  localparam int M_DEF = 2;  // ROM address width
  localparam int C_DEF = 8;  // burst length field width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/rom_adr_counter.sv
// Loadable up-counter that wraps at L-1 back to 0. Depth L does not have to
// be a power of two, so the wrap is explicit rather than relying on overflow.
module rom_adr_counter #(
  parameter int L = 4,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [M-1:0] load_val,
  input  logic         inc,
  output logic [M-1:0] count
);

  localparam logic [M-1:0] LAST_ADR = M'(L - 1);

  // Address register: load has priority over increment.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= (count == LAST_ADR) ? '0 : count + M'(1);
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Walks a burst of consecutive ROM addresses (modulo depth) and presents each
// word on a valid/ready stream with a last flag, one word per cycle.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int L = L_DEF,
  parameter int M = M_DEF,
  parameter int C = C_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] start_adr,
  input  logic [C-1:0] burst_len,
  output logic [M-1:0] read_adr,
  input  logic [K-1:0] rom_data,
  output logic [K-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [M:0] DEPTH = (M + 1)'(L);

  state_t       state, state_nxt;
  logic [C-1:0] remaining;
  logic         err_flag;
  logic         adr_load;
  logic         adr_inc;
  logic         hs;
  logic         adr_ok;
  logic         len_zero;

  assign hs       = out_valid & out_ready;
  assign adr_ok   = {1'b0, start_adr} < DEPTH;
  assign len_zero = (burst_len == '0);

  rom_adr_counter #(
    .L(L),
    .M(M)
  ) u_adr (
    .clk      (clk),
    .rst      (rst),
    .load     (adr_load),
    .load_val (start_adr),
    .inc      (adr_inc),
    .count    (read_adr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and address counter controls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt = state;
    adr_load  = 1'b0;
    adr_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!adr_ok || len_zero) begin
            state_nxt = FIN;
          end else begin
            adr_load  = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        adr_inc   = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (out_last) state_nxt = FIN;
          else          adr_inc   = 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stream datapath: output word, last flag, remaining count and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      remaining <= '0;
      err_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!adr_ok)       err_flag  <= 1'b1;
            else if (!len_zero) remaining <= burst_len;
          end
        end
        FETCH: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          out_last  <= (remaining == C'(1));
          remaining <= remaining - C'(1);
        end
        STREAM: begin
          if (hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_data  <= rom_data;
              out_last  <= (remaining == C'(1));
              remaining <= remaining - C'(1);
            end
          end
        end
        FIN: begin
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign err  = done & err_flag;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: two instances (depth 4 and depth 3) share one
// set of stimulus; a selector routes start and observes the chosen instance.
// Expected words come from a plain list model: rom[(adr+i) % depth].
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] start_adr;
  logic [7:0] burst_len;
  logic       out_ready;
  bit         sel;  // 0: depth-4 instance, 1: depth-3 instance

  logic [1:0] read_adr4, read_adr3;
  logic [7:0] rom_data4, rom_data3;
  logic [7:0] out_data4, out_data3;
  logic       out_valid4, out_valid3, out_last4, out_last3;
  logic       busy4, busy3, done4, done3, err4, err3;

  logic [7:0] o_data;
  logic [1:0] o_adr;
  logic       o_valid, o_last, o_busy, o_done, o_err;

  logic [7:0] rom [4];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    rom[0] = 8'd5; rom[1] = 8'd6; rom[2] = 8'd7; rom[3] = 8'd8;
  end

  // Combinational ROMs in front of each instance.
  assign rom_data4 = rom[read_adr4];
  assign rom_data3 = rom[read_adr3];

  rom_burst_reader #(.K(8), .L(4), .M(2), .C(8)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .start_adr(start_adr),
    .burst_len(burst_len), .read_adr(read_adr4), .rom_data(rom_data4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_last(out_last4), .busy(busy4), .done(done4), .err(err4)
  );

  rom_burst_reader #(.K(8), .L(3), .M(2), .C(8)) dut3 (
    .clk(clk), .rst(rst), .start(start & sel), .start_adr(start_adr),
    .burst_len(burst_len), .read_adr(read_adr3), .rom_data(rom_data3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_last(out_last3), .busy(busy3), .done(done3), .err(err3)
  );

  always_comb begin
    o_data  = sel ? out_data3  : out_data4;
    o_adr   = sel ? read_adr3  : read_adr4;
    o_valid = sel ? out_valid3 : out_valid4;
    o_last  = sel ? out_last3  : out_last4;
    o_busy  = sel ? busy3      : busy4;
    o_done  = sel ? done3      : done4;
    o_err   = sel ? err3       : err4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one burst. mode: 0 ready always high, 1 ready pattern 1,0,0,
  // 2 random ready. poke re-pulses start (different address) mid-burst.
  task automatic run_burst(input bit d3, input int adr, input int len,
                           input int mode, input bit poke);
    int         depth;
    int         nwords;
    int         cyc;
    bit         seen_done;
    bit         hs_last;
    bit         hold;
    logic [7:0] pdata;
    logic       plast;
    logic [7:0] expq[$];
    logic [7:0] w;
    depth = d3 ? 3 : 4;
    sel   = d3;
    if (adr < depth)
      for (int i = 0; i < len; i++) expq.push_back(rom[(adr + i) % depth]);
    nwords = expq.size();

    @(negedge clk);
    start     = 1'b1;
    start_adr = 2'(adr);
    burst_len = 8'(len);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", o_busy, 1'b1);

    cyc = 0; seen_done = 0; hs_last = 0; hold = 0; pdata = '0; plast = 0;
    while (!seen_done && cyc < 300) begin
      if (hs_last || (nwords == 0 && cyc == 0))
        check("done_when_due", o_done, 1'b1);
      if (o_done) begin
        seen_done = 1;
        check("done_not_early", hs_last || (nwords == 0 && cyc == 0), 1'b1);
        check("done_words_left", expq.size(), 0);
        check("err_value", o_err, (adr >= depth) ? 1'b1 : 1'b0);
        check("valid_at_done", o_valid, 1'b0);
      end
      if (hold) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_data", o_data, pdata);
        check("hold_last", o_last, plast);
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (o_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_word", 1'b1, 1'b0);
        end else begin
          w = expq.pop_front();
          check("word_data", o_data, w);
          check("word_last", o_last, (expq.size() == 0) ? 1'b1 : 1'b0);
        end
      end else if (o_valid) begin
        check("last_flag_stall", o_last, (expq.size() == 1) ? 1'b1 : 1'b0);
      end
      hold    = o_valid && !out_ready;
      pdata   = o_data;
      plast   = o_last;
      hs_last = o_valid && out_ready && o_last;
      start   = poke && (cyc == 2) && !o_done;
      if (start) start_adr = 2'((adr + 1) % depth);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("burst_completed", seen_done, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("idle_busy", o_busy, 1'b0);
      check("idle_valid", o_valid, 1'b0);
      check("idle_done", o_done, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    int hs_cnt;
    int cyc;
    rst = 1'b1; start = 1'b0; start_adr = '0; burst_len = '0;
    out_ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_adr", read_adr4, 0);
    check("rst_data", out_data4, 0);
    check("rst_valid", out_valid4, 0);
    check("rst_last", out_last4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_err", err4, 0);
    rst = 1'b0;

    // Directed scenarios.
    run_burst(0, 1, 3, 0, 0);   // 6,7,8
    run_burst(0, 2, 6, 0, 0);   // 7,8,5,6,7,8
    run_burst(0, 0, 4, 1, 0);   // ready stalls
    run_burst(0, 0, 0, 0, 0);   // empty burst
    run_burst(1, 3, 2, 0, 0);   // out of range on depth 3 -> err
    run_burst(1, 3, 0, 0, 0);   // out of range with zero length -> err
    run_burst(1, 1, 5, 0, 0);   // 6,7,5,6,7 (wrap 2->0 on depth 3)
    run_burst(0, 1, 9, 0, 1);   // start re-pulsed mid-burst is ignored

    // Reset in the middle of a burst.
    sel = 0;
    @(negedge clk);
    start = 1'b1; start_adr = 2'd0; burst_len = 8'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs_cnt = 0; cyc = 0;
    while (hs_cnt < 2 && cyc < 50) begin
      if (out_valid4 && out_ready) hs_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("mid_valid_before_rst", out_valid4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_adr", read_adr4, 0);
    check("midrst_data", out_data4, 0);
    check("midrst_valid", out_valid4, 0);
    check("midrst_last", out_last4, 0);
    check("midrst_busy", busy4, 0);
    check("midrst_done", done4, 0);
    check("midrst_err", err4, 0);
    run_burst(0, 3, 1, 0, 0);   // single word 8 with last

    // Randomized bursts on both depths.
    for (int n = 0; n < 24; n++) begin
      run_burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 10)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
